id_scoreboard: RTL and testbench
================================

# id_scoreboard

Register scoreboard and issue controller for the decode stage. Tracks, per architectural register, how many issued instructions still owe a write-back. It gates decode issue on RAW hazards (rs1/rs2 pending) and on write-count saturation (rd counter full). It sits between `id` (source/dest fields plus `rs1/rs2_req_rd_valid`) and the write-back stage, and is the single source of `stall` for the front end.

## Interface
Parameters:
- `REG_NUM`, 32: number of architectural registers; x0 is never tracked.
- `ADDR_W`, 5: register address width; must be at least clog2(`REG_NUM`).
- `CNT_W`, 2: per-register pending-write counter width; maximum outstanding writes per register is 2^`CNT_W`-1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `flush_i`  in  1  pipeline flush; clears all counters.
- `id_valid_i`  in  1  decode holds an instruction.
- `id_rs1_i`, `id_rs2_i`  in  `ADDR_W`  source register addresses.
- `id_rs1_rd_valid_i`, `id_rs2_rd_valid_i`  in  1  the corresponding source register is actually read.
- `id_rd_i`  in  `ADDR_W`  destination register address.
- `id_rd_we_i`  in  1  the instruction writes `id_rd_i`.
- `wb_valid_i`  in  1  write-back retires a register write.
- `wb_rd_i`  in  `ADDR_W`  register being retired.
- `id_ready_o`  out  1  issue permitted this cycle.
- `issue_o`  out  1  handshake fire: `id_valid_i` & `id_ready_o`.
- `stall_o`  out  1  `id_valid_i` & ~`id_ready_o`.
- `busy_o`  out  `REG_NUM`  bit i = counter[i] != 0; bit 0 is constant 0.
- `stall_cnt_o`  out  32  saturating count of cycles with `stall_o` high.
- `sb_err_o`  out  1  sticky error; set on write-back underflow.

## Operation
- Hazard terms are computed combinationally from registered counters only. There is no write-back bypass.
  - `raw1` = `id_rs1_rd_valid_i` & rs1≠0 & cnt[rs1]≠0.
  - `raw2` = the same for rs2.
  - `waw` = `id_rd_we_i` & rd≠0 & cnt[rd]==max.
- `id_ready_o` = ~(`raw1`|`raw2`|`waw`) & ~`flush_i`.
- Counter update per register i at each edge, in priority order:
  - `flush_i` → 0.
  - Otherwise inc = `issue_o` & `id_rd_we_i` & rd==i; dec = `wb_valid_i` & wb_rd==i & cnt[i]≠0.
  - Both inc and dec → unchanged. Inc only → +1. Dec only → -1.
- Accesses to x0 are ignored: issue to rd 0 and write-back to rd 0 change nothing and never raise an error.
- Underflow: `wb_valid_i` to rd≠0 while cnt==0 (and not a simultaneous issue to the same rd) sets `sb_err_o`; the counter stays 0. `sb_err_o` is cleared only by reset; `flush_i` does not clear it.
- Inc never overflows, because `waw` blocks issue when the counter is at max.
- `stall_cnt_o` increments every cycle `stall_o`=1 and saturates at 0xFFFF_FFFF. It is cleared only by reset.

## Timing
- Reset (async, `rst_n`=0) values:
  - All counters 0.
  - `busy_o`=0, `sb_err_o`=0, `stall_cnt_o`=0.
  - `id_ready_o`=1 when `flush_i`=0; `issue_o`=`id_valid_i`; `stall_o`=0.
- Reset mid-operation discards all pending counts immediately, with no clock needed.
- `id_ready_o`, `issue_o` and `stall_o` have zero-cycle latency (combinational).
- Counter and `busy_o` changes are visible one cycle after the triggering edge.
- A write-back in cycle N releases a dependent source in cycle N+1.
- A flush in cycle N forces `id_ready_o`=0 in cycle N, and the state is clean in cycle N+1.
- `stall_cnt_o` and `sb_err_o` are registered and update one cycle after the event.

## Structure
- Shared package/`define.v` holds:
  - `ADDR_W` and `REG_NUM`.
  - `Enable`/`Disable`/`RstEnable` macros.
  - The x0 constant.
- Sub-module `sb_cnt`: a `CNT_W`-bit up/down counter with inc, dec, clr and async reset. It outputs `nz` and `full` and is instantiated for registers 1..`REG_NUM`-1.
- The top level holds the hazard logic, issue handshake, error flag and stall counter.

## Test plan
- Reset then issue `addi x5` (rd=5, we=1) with `id_valid_i`=1.
  - `issue_o`=1, and `busy_o[5]`=1 next cycle.
  - A following read of rs1=5 gives `stall_o`=1 until `wb_valid_i`/`wb_rd_i`=5, then `id_ready_o`=1 one cycle after.
- Issue rd=7 three times with no write-back.
  - The fourth issue with rd=7 has `id_ready_o`=0 (`waw`).
  - One write-back to 7 makes the fourth issue fire next cycle.
- Issue rd=9 and write back rd=9 in the same cycle while cnt[9]=1.
  - cnt[9] stays 1, and `sb_err_o` stays 0.
- Write back rd=12 with cnt[12]=0.
  - `sb_err_o`=1 next cycle and remains 1 after a flush.
  - Write-back to rd=0 never sets it.
- Pend x3, x4 and x8, then pulse `flush_i`.
  - `id_ready_o`=0 during the pulse.
  - `busy_o`=0 next cycle, and `stall_cnt_o` is unchanged by the flush.
- Hold a RAW stall for 10 cycles: `stall_cnt_o`=10.
- Assert `rst_n`=0 mid-stall with no clock edge: all counters, `busy_o`, `stall_cnt_o` and `sb_err_o` read 0 immediately.

Source files
------------

// File: rtl/id_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// id_scoreboard_pkg
//
// Purpose:
//   Shared constants and helpers for the decode-stage register scoreboard.
//   It holds the default register-file geometry and the enable/disable/reset
//   level constants. It also holds the x0 address constant and the
//   counter-operation encoding used by the per-register counters.
//
// Contents:
//   REG_NUM_DEF, ADDR_W_DEF, CNT_W_DEF  default scoreboard geometry
//   ENABLE / DISABLE / RST_ENABLE       signal level constants
//   X0_ADDR                             hard-wired zero register address
//   cnt_op_e, cnt_op()                  counter operation decode
// ---------------------------------------------------------------------------
package id_scoreboard_pkg;

    // Default geometry: 32 architectural registers, 5-bit addresses and up to
    // three outstanding writes per register.
    localparam int REG_NUM_DEF = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int CNT_W_DEF   = 2;

    // Level constants shared across the decode stage.
    localparam logic ENABLE     = 1'b1;
    localparam logic DISABLE    = 1'b0;
    localparam logic RST_ENABLE = 1'b0;

    // x0 reads as zero and is never written, so it is never tracked.
    localparam int X0_ADDR = 0;

    // Operation a pending-write counter performs on the next clock edge.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2,
        CNT_CLR  = 2'd3
    } cnt_op_e;

    // Clear has priority over everything else. When an increment and a
    // decrement land on the same edge, they cancel and the counter holds.
    function automatic cnt_op_e cnt_op(input logic clr, input logic inc, input logic dec);
        cnt_op_e op;
        op = CNT_HOLD;
        if (clr == ENABLE) begin
            op = CNT_CLR;
        end else if (inc && !dec) begin
            op = CNT_INC;
        end else if (dec && !inc) begin
            op = CNT_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/id_scoreboard_sb_cnt.sv
// ---------------------------------------------------------------------------
// sb_cnt
//
// Purpose:
//   Up/down counter of outstanding write-backs for one architectural
//   register.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous clear (pipeline flush)
//   inc    in   one more write issued to this register
//   dec    in   one write retired for this register
//   cnt    out  CNT_W-bit current count
//   nz     out  count is non-zero (register has a pending write)
//   full   out  count is at its maximum value
// ---------------------------------------------------------------------------
module sb_cnt
    import id_scoreboard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             nz,
    output logic             full
);

    cnt_op_e op;

    // Decode this cycle's request into a single counter operation.
    always_comb begin
        op = cnt_op(clr, inc, dec);
    end

    // Counter register. The full/nz guards mean that a stray increment at
    // maximum or a stray decrement at zero leaves the counter unchanged and
    // does not wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            cnt <= '0;
        end else begin
            case (op)
                CNT_CLR: cnt <= '0;
                CNT_INC: if (!full) cnt <= cnt + 1'b1;
                CNT_DEC: if (nz) cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Status flags used by the hazard logic in the top level.
    always_comb begin
        nz   = |cnt;
        full = &cnt;
    end

endmodule

// File: rtl/id_scoreboard.sv
// ---------------------------------------------------------------------------
// id_scoreboard
//
// Purpose:
//   Register scoreboard and issue controller for the decode stage. It keeps a
//   count, per architectural register, of issued instructions that have not
//   yet written back. Issue is blocked on read-after-write hazards and when
//   the destination's counter is saturated. This block is the single source
//   of the front-end stall.
//
// Ports:
//   clk, rst_n                    clock and asynchronous active-low reset
//   flush_i                       clears all counters and blocks issue this cycle
//   id_valid_i                    decode holds an instruction
//   id_rs1_i / id_rs2_i           source register addresses
//   id_rs1_rd_valid_i / _rs2_     the source is actually read
//   id_rd_i, id_rd_we_i           destination address and write enable
//   wb_valid_i, wb_rd_i           write-back retiring a register write
//   id_ready_o                    issue permitted this cycle
//   issue_o                       id_valid_i & id_ready_o
//   stall_o                       id_valid_i & ~id_ready_o
//   busy_o                        per-register pending flag (bit 0 always 0)
//   stall_cnt_o                   saturating count of stalled cycles
//   sb_err_o                      sticky write-back underflow flag
// ---------------------------------------------------------------------------
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               id_valid_i,
    input  logic [ADDR_W-1:0]  id_rs1_i,
    input  logic [ADDR_W-1:0]  id_rs2_i,
    input  logic               id_rs1_rd_valid_i,
    input  logic               id_rs2_rd_valid_i,
    input  logic [ADDR_W-1:0]  id_rd_i,
    input  logic               id_rd_we_i,
    input  logic               wb_valid_i,
    input  logic [ADDR_W-1:0]  wb_rd_i,
    output logic               id_ready_o,
    output logic               issue_o,
    output logic               stall_o,
    output logic [REG_NUM-1:0] busy_o,
    output logic [31:0]        stall_cnt_o,
    output logic               sb_err_o
);

    localparam logic [ADDR_W-1:0] X0 = ADDR_W'(X0_ADDR);

    // Per-register status. Entry 0 is tied off so that indexing by an
    // address of x0 always reports "no pending write".
    logic [REG_NUM-1:0] cnt_nz;
    logic [REG_NUM-1:0] cnt_full;
    logic [REG_NUM-1:1] cnt_inc;
    logic [REG_NUM-1:1] cnt_dec;

    logic raw1;
    logic raw2;
    logic waw;
    logic wb_underflow;

    assign cnt_nz[0]   = DISABLE;
    assign cnt_full[0] = DISABLE;

    // One pending-write counter per tracked register (x1 and up).
    for (genvar g = 1; g < REG_NUM; g++) begin : g_cnt
        logic [CNT_W-1:0] cnt_val;

        sb_cnt #(
            .CNT_W (CNT_W)
        ) u_sb_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (flush_i),
            .inc   (cnt_inc[g]),
            .dec   (cnt_dec[g]),
            .cnt   (cnt_val),
            .nz    (cnt_nz[g]),
            .full  (cnt_full[g])
        );
    end

    // Hazard detection. This uses only the registered counter state: a
    // write-back in this cycle does not release a dependent source until the
    // next cycle, so no bypass path exists.
    always_comb begin
        raw1 = id_rs1_rd_valid_i && (id_rs1_i != X0) && cnt_nz[id_rs1_i];
        raw2 = id_rs2_rd_valid_i && (id_rs2_i != X0) && cnt_nz[id_rs2_i];
        waw  = id_rd_we_i && (id_rd_i != X0) && cnt_full[id_rd_i];
    end

    // Issue handshake. A flush blocks issue in the same cycle, so nothing
    // can be counted into state that is about to be discarded.
    always_comb begin
        id_ready_o = !(raw1 || raw2 || waw) && !flush_i;
        issue_o    = id_valid_i && id_ready_o;
        stall_o    = id_valid_i && !id_ready_o;
    end

    // Per-register increment/decrement requests. A decrement is only raised
    // when the counter is non-zero, so retiring an untracked write leaves
    // the counter alone. Writes to x0 never reach a counter.
    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            cnt_inc[i] = issue_o && id_rd_we_i && (id_rd_i == ADDR_W'(i));
            cnt_dec[i] = wb_valid_i && (wb_rd_i == ADDR_W'(i)) && cnt_nz[i];
        end
    end

    // A write-back is an underflow when its register has nothing pending.
    // There are two exceptions: retiring x0, and a write-back that coincides
    // with an issue to the same register, which the counter absorbs.
    always_comb begin
        wb_underflow = wb_valid_i
                    && (wb_rd_i != X0)
                    && !cnt_nz[wb_rd_i]
                    && !(issue_o && id_rd_we_i && (id_rd_i == wb_rd_i));
    end

    assign busy_o = cnt_nz;

    // Sticky error flag. Only reset clears it; a flush leaves the record of
    // the protocol violation in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            sb_err_o <= DISABLE;
        end else if (wb_underflow) begin
            sb_err_o <= ENABLE;
        end
    end

    // Stalled-cycle performance counter. It saturates instead of wrapping and
    // is independent of flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_id_scoreboard
//
// Directed, table-driven bench for id_scoreboard. Each table entry gives
// one cycle of decode/write-back inputs with the hand-computed ready, busy
// and error values expected in that cycle. Hand-written sequences cover the
// stall counter and an asynchronous reset applied mid-stall.
// ---------------------------------------------------------------------------
module tb_id_scoreboard;

    localparam int REG_NUM = 32;
    localparam int ADDR_W  = 5;
    localparam int CNT_W   = 2;

    logic               clk;
    logic               rst_n;
    logic               flush_i;
    logic               id_valid_i;
    logic [ADDR_W-1:0]  id_rs1_i;
    logic [ADDR_W-1:0]  id_rs2_i;
    logic               id_rs1_rd_valid_i;
    logic               id_rs2_rd_valid_i;
    logic [ADDR_W-1:0]  id_rd_i;
    logic               id_rd_we_i;
    logic               wb_valid_i;
    logic [ADDR_W-1:0]  wb_rd_i;
    logic               id_ready_o;
    logic               issue_o;
    logic               stall_o;
    logic [REG_NUM-1:0] busy_o;
    logic [31:0]        stall_cnt_o;
    logic               sb_err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              flush;
        logic              valid;
        logic [ADDR_W-1:0] rs1;
        logic              rs1v;
        logic [ADDR_W-1:0] rs2;
        logic              rs2v;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic              wbv;
        logic [ADDR_W-1:0] wbrd;
        logic              exp_ready;
        logic [31:0]       exp_busy;
        logic              exp_err;
    } vec_t;

    vec_t vq[$];

    id_scoreboard #(
        .REG_NUM (REG_NUM),
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush_i           (flush_i),
        .id_valid_i        (id_valid_i),
        .id_rs1_i          (id_rs1_i),
        .id_rs2_i          (id_rs2_i),
        .id_rs1_rd_valid_i (id_rs1_rd_valid_i),
        .id_rs2_rd_valid_i (id_rs2_rd_valid_i),
        .id_rd_i           (id_rd_i),
        .id_rd_we_i        (id_rd_we_i),
        .wb_valid_i        (wb_valid_i),
        .wb_rd_i           (wb_rd_i),
        .id_ready_o        (id_ready_o),
        .issue_o           (issue_o),
        .stall_o           (stall_o),
        .busy_o            (busy_o),
        .stall_cnt_o       (stall_cnt_o),
        .sb_err_o          (sb_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input bit f, input bit v, input int rs1, input bit r1v,
                           input int rs2, input bit r2v, input int rd, input bit we,
                           input bit wbv, input int wbrd, input bit er,
                           input logic [31:0] eb, input bit ee);
        vec_t t;
        t.flush     = f;
        t.valid     = v;
        t.rs1       = ADDR_W'(rs1);
        t.rs1v      = r1v;
        t.rs2       = ADDR_W'(rs2);
        t.rs2v      = r2v;
        t.rd        = ADDR_W'(rd);
        t.we        = we;
        t.wbv       = wbv;
        t.wbrd      = ADDR_W'(wbrd);
        t.exp_ready = er;
        t.exp_busy  = eb;
        t.exp_err   = ee;
        vq.push_back(t);
    endtask

    task automatic drive_idle();
        flush_i           = 1'b0;
        id_valid_i        = 1'b0;
        id_rs1_i          = '0;
        id_rs2_i          = '0;
        id_rs1_rd_valid_i = 1'b0;
        id_rs2_rd_valid_i = 1'b0;
        id_rd_i           = '0;
        id_rd_we_i        = 1'b0;
        wb_valid_i        = 1'b0;
        wb_rd_i           = '0;
    endtask

    // Drive one vector at the falling edge, then settle before sampling.
    task automatic apply_stimulus(input vec_t t);
        @(negedge clk);
        flush_i           = t.flush;
        id_valid_i        = t.valid;
        id_rs1_i          = t.rs1;
        id_rs2_i          = t.rs2;
        id_rs1_rd_valid_i = t.rs1v;
        id_rs2_rd_valid_i = t.rs2v;
        id_rd_i           = t.rd;
        id_rd_we_i        = t.we;
        wb_valid_i        = t.wbv;
        wb_rd_i           = t.wbrd;
        #1;
    endtask

    initial begin
        // flush valid rs1 r1v rs2 r2v rd we wbv wbrd | ready busy err
        add_vec(0,1, 0,0, 0,0,  5,1, 0, 0, 1, 32'h0,   0); // 0  issue x5
        add_vec(0,1, 5,1, 0,0,  6,0, 0, 0, 0, 32'h20,  0); // 1  RAW on x5
        add_vec(0,1, 5,1, 0,0,  6,0, 1, 5, 0, 32'h20,  0); // 2  wb x5, still stalled
        add_vec(0,1, 5,1, 0,0,  6,0, 0, 0, 1, 32'h0,   0); // 3  released
        add_vec(0,1, 0,0, 0,0,  7,1, 0, 0, 1, 32'h0,   0); // 4  x7 -> 1
        add_vec(0,1, 0,0, 0,0,  7,1, 0, 0, 1, 32'h80,  0); // 5  x7 -> 2
        add_vec(0,1, 0,0, 0,0,  7,1, 0, 0, 1, 32'h80,  0); // 6  x7 -> 3
        add_vec(0,1, 0,0, 0,0,  7,1, 0, 0, 0, 32'h80,  0); // 7  WAW full
        add_vec(0,1, 0,0, 0,0,  7,1, 1, 7, 0, 32'h80,  0); // 8  wb x7 -> 2
        add_vec(0,1, 0,0, 0,0,  7,1, 0, 0, 1, 32'h80,  0); // 9  fires -> 3
        add_vec(0,0, 0,0, 0,0,  0,0, 1, 7, 1, 32'h80,  0); // 10 -> 2
        add_vec(0,0, 0,0, 0,0,  0,0, 1, 7, 1, 32'h80,  0); // 11 -> 1
        add_vec(0,0, 0,0, 0,0,  0,0, 1, 7, 1, 32'h80,  0); // 12 -> 0
        add_vec(0,0, 0,0, 0,0,  0,0, 0, 0, 1, 32'h0,   0); // 13
        add_vec(0,1, 0,0, 0,0,  9,1, 0, 0, 1, 32'h0,   0); // 14 x9 -> 1
        add_vec(0,1, 0,0, 0,0,  9,1, 1, 9, 1, 32'h200, 0); // 15 inc+dec -> 1
        add_vec(0,0, 0,0, 0,0,  0,0, 1, 9, 1, 32'h200, 0); // 16 -> 0
        add_vec(0,0, 0,0, 0,0,  0,0, 1,12, 1, 32'h0,   0); // 17 underflow x12
        add_vec(0,0, 0,0, 0,0,  0,0, 1, 0, 1, 32'h0,   1); // 18 wb x0 ignored
        add_vec(0,1, 0,0, 0,0,  0,1, 0, 0, 1, 32'h0,   1); // 19 issue rd x0
        add_vec(0,1, 0,1, 0,1,  0,0, 0, 0, 1, 32'h0,   1); // 20 read x0 twice
        add_vec(0,1, 0,0, 0,0,  3,1, 0, 0, 1, 32'h0,   1); // 21 pend x3
        add_vec(0,1, 0,0, 0,0,  4,1, 0, 0, 1, 32'h8,   1); // 22 pend x4
        add_vec(0,1, 0,0, 0,0,  8,1, 0, 0, 1, 32'h18,  1); // 23 pend x8
        add_vec(1,0, 0,0, 0,0,  0,0, 0, 0, 0, 32'h118, 1); // 24 flush pulse
        add_vec(0,0, 0,0, 0,0,  0,0, 0, 0, 1, 32'h0,   1); // 25 clean, err sticky
        add_vec(0,1, 0,0, 0,0, 10,1, 0, 0, 1, 32'h0,   1); // 26 pend x10
        add_vec(0,1,10,0,10,1,  0,0, 0, 0, 0, 32'h400, 1); // 27 RAW on rs2
        add_vec(0,1,10,0,10,0,  0,0, 0, 0, 1, 32'h400, 1); // 28 sources not read
        add_vec(0,0, 0,0, 0,0,  0,0, 1,10, 1, 32'h400, 1); // 29 wb x10
        add_vec(0,0, 0,0, 0,0,  0,0, 0, 0, 1, 32'h0,   1); // 30

        // Reset state, with a valid instruction presented during reset.
        drive_idle();
        rst_n = 1'b0;
        id_valid_i = 1'b1;
        #2;
        check_output("reset busy", busy_o, 32'h0);
        check_output("reset stall_cnt", stall_cnt_o, 32'h0);
        check_output("reset sb_err", {31'h0, sb_err_o}, 32'h0);
        check_output("reset ready", {31'h0, id_ready_o}, 32'h1);
        check_output("reset issue", {31'h0, issue_o}, 32'h1);
        check_output("reset stall", {31'h0, stall_o}, 32'h0);
        id_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < vq.size(); i++) begin
            apply_stimulus(vq[i]);
            check_output($sformatf("v%0d ready", i), {31'h0, id_ready_o}, {31'h0, vq[i].exp_ready});
            check_output($sformatf("v%0d issue", i), {31'h0, issue_o},
                         {31'h0, vq[i].valid & vq[i].exp_ready});
            check_output($sformatf("v%0d stall", i), {31'h0, stall_o},
                         {31'h0, vq[i].valid & ~vq[i].exp_ready});
            check_output($sformatf("v%0d busy", i), busy_o, vq[i].exp_busy);
            check_output($sformatf("v%0d sb_err", i), {31'h0, sb_err_o}, {31'h0, vq[i].exp_err});
        end

        // Stalls occurred in vectors 1, 2, 7, 8 and 27. The flush pulse had no
        // valid instruction, so it added nothing.
        @(negedge clk);
        drive_idle();
        #1;
        check_output("table stall_cnt", stall_cnt_o, 32'd5);
        check_output("table busy end", busy_o, 32'h0);
        check_output("table sb_err sticky", {31'h0, sb_err_o}, 32'h1);

        // Asynchronous reset between clock edges, then a fresh stall sequence.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        check_output("reset2 stall_cnt", stall_cnt_o, 32'h0);
        check_output("reset2 sb_err", {31'h0, sb_err_o}, 32'h0);

        // Issue to x15 and underflow x12 in the same cycle.
        @(negedge clk);
        id_valid_i = 1'b1;
        id_rd_i    = 5'd15;
        id_rd_we_i = 1'b1;
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd12;
        #1;
        check_output("seq issue x15", {31'h0, issue_o}, 32'h1);

        // Hold a RAW stall on x15 for ten cycles.
        @(negedge clk);
        id_rd_i           = 5'd0;
        id_rd_we_i        = 1'b0;
        wb_valid_i        = 1'b0;
        wb_rd_i           = '0;
        id_rs1_i          = 5'd15;
        id_rs1_rd_valid_i = 1'b1;
        #1;
        check_output("seq sb_err set", {31'h0, sb_err_o}, 32'h1);
        check_output("seq busy x15", busy_o, 32'h8000);
        check_output("seq stall start", {31'h0, stall_o}, 32'h1);
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            #1;
            check_output($sformatf("seq stall_cnt c%0d", c), stall_cnt_o, 32'(c));
        end
        @(negedge clk);
        #1;
        check_output("seq stall_cnt 10", stall_cnt_o, 32'd10);
        check_output("seq still stalled", {31'h0, stall_o}, 32'h1);

        // Asynchronous reset mid-stall, with no clock edge involved.
        #1;
        rst_n = 1'b0;
        #1;
        check_output("midreset busy", busy_o, 32'h0);
        check_output("midreset stall_cnt", stall_cnt_o, 32'h0);
        check_output("midreset sb_err", {31'h0, sb_err_o}, 32'h0);
        check_output("midreset ready", {31'h0, id_ready_o}, 32'h1);
        check_output("midreset stall", {31'h0, stall_o}, 32'h0);

        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
